lcm_calculator: RTL and testbench
=================================

Name: lcm_calculator

Overview:
- Sequential, multi-cycle least-common-multiple unit with a start/done handshake. It is the companion to the team's combinational HCF block.
- Internally it runs a subtractive HCF, then an exact restoring division a/HCF, then a shift-add multiply (a/HCF)*b.
- Both HCF and LCM are returned as registered results.
- Intended for control-path use where a combinational loop is unacceptable.

Parameters:
N, 8, operand width in bits (N >= 2); LCM output is 2N bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
in1  input  N  operand a, unsigned, sampled with start
in2  input  N  operand b, unsigned, sampled with start
busy  output  1  high whenever FSM is not in IDLE
done  output  1  one-cycle pulse, results valid and updated
hcf  output  N  registered highest common factor
lcm  output  2N  registered least common multiple

Behaviour:
- Reset: rst=1 at a clock edge forces FSM to IDLE and clears busy, done, hcf and lcm to 0. This applies mid-operation, and the operation in progress is aborted.
- If rst and start are both high on the same edge, rst wins.
- States are IDLE, GCD, DIV, MUL, FINISH. busy = (state != IDLE).
- IDLE:
  - On an edge with start=1, latch a=in1 and b=in2 into working registers x=a and y=b.
  - If a==0 or b==0, go to FINISH. Otherwise go to GCD.
  - start=0 stays in IDLE.
- GCD, one step per cycle:
  - x==y: g<=x, clear the iteration counter, go to DIV.
  - x>y: x<=x-y.
  - else: y<=y-x.
  - G = number of subtraction steps + 1 (e.g. G=1 when a==b).
- DIV: N-cycle restoring division a/g, MSB first, one quotient bit per cycle. The remainder is 0 by construction; quotient q is N bits.
- MUL: N-cycle shift-add of q*b into a 2N-bit accumulator. The result cannot overflow 2N bits.
- FINISH (1 cycle):
  - Nonzero case: hcf<=g, lcm<=product.
  - Zero case: hcf<=a|b (HCF(x,0)=x, HCF(0,0)=0), lcm<=0.
  - done=1 in the cycle after the FINISH edge registers results, then FSM returns to IDLE.
- Latency, taking E0 as the start-accept edge and cycle 1 as the cycle following E0:
  - Nonzero operands: done is high in cycle G+2N+1.
  - Either operand zero: done is high in cycle 1.
  - done coincides with busy=1 for that single cycle. A new start is accepted from the following cycle (busy=0).
- start while busy=1 is ignored, and in1/in2 changes while busy have no effect.
- hcf and lcm hold their values from FINISH until the next FINISH. They are never visible mid-computation.
- done is exactly one cycle wide and is never asserted outside FINISH completion.
- All arithmetic is unsigned, and widths are explicit. Subtraction in GCD never underflows because only the larger operand is reduced.

Test Plan:
- N=8, rst released, start with in1=12, in2=18 -> G=3; done in cycle 20; hcf=6, lcm=36; busy low in cycle 21.
- start with in1=7, in2=7 -> G=1; done in cycle 18; hcf=7, lcm=7.
- start with in1=255, in2=254 -> G=255; done in cycle 272; hcf=1, lcm=64770 (0xFD02). This is the max-iteration, full-width product case.
- start with in1=0, in2=9 -> done in cycle 1, hcf=9, lcm=0. Then in1=0, in2=0 -> hcf=0, lcm=0.
- Sequence:
  - start in1=12, in2=18, then pulse start with in1=5, in2=3 in cycle 4 (busy=1) -> second request ignored; result hcf=6, lcm=36.
  - After busy falls, start in1=5, in2=3 -> hcf=1, lcm=15.
- Reset mid-operation: start in1=12, in2=18, assert rst in cycle 10 (DIV) -> next cycle busy=0, done=0, hcf=0, lcm=0, and no done pulse follows.
  - Same edge with rst=1 and start=1 -> FSM stays IDLE.

Source files
------------

// File: rtl/lcm_calculator.sv
// lcm_calculator: sequential least-common-multiple unit with a start/done
// handshake. A subtractive HCF runs first, then an exact restoring division
// a/HCF, then a shift-add multiply (a/HCF)*b. HCF and LCM are registered and
// only change when a computation completes.
module lcm_calculator #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   hcf,
  output logic [2*N-1:0] lcm
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD,
    S_DIV,
    S_MUL,
    S_FINISH
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [N-1:0]     hcf_q;
  logic [2*N-1:0]   lcm_q;

  // Working registers; never observed outside, so they carry no reset.
  logic [N-1:0]     x_q;
  logic [N-1:0]     y_q;
  logic [N-1:0]     g_q;
  logic [N-1:0]     dvd_q;
  logic [N-1:0]     rem_q;
  logic [N-1:0]     quo_q;
  logic [2*N-1:0]   mcand_q;
  logic [2*N-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;

  // Datapath next values for one division step and one multiply step.
  logic [N-1:0]     rem_sh_lo_d;
  logic [N-1:0]     rem_diff_d;
  logic             rem_ge_d;
  logic [N-1:0]     rem_d;
  logic [2*N-1:0]   acc_d;

  // One restoring-division step and one shift-add step. The shifted remainder
  // is N+1 bits wide; its top bit is rem_q[N-1], and when that bit is set the
  // value is certainly >= g, while the modular N-bit difference is still exact
  // because the true difference is below g.
  always_comb begin
    rem_sh_lo_d = {rem_q[N-2:0], dvd_q[N-1]};
    rem_ge_d    = rem_q[N-1] | (rem_sh_lo_d >= g_q);
    rem_diff_d  = rem_sh_lo_d - g_q;
    rem_d       = rem_ge_d ? rem_diff_d : rem_sh_lo_d;
    acc_d       = acc_q + (quo_q[0] ? mcand_q : '0);
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hcf_q   <= '0;
      lcm_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= in1;
            y_q     <= in2;
            dvd_q   <= in1;
            mcand_q <= {{N{1'b0}}, in2};
            busy_q  <= 1'b1;
            if ((in1 == '0) || (in2 == '0)) begin
              // HCF(x,0)=x and HCF(0,0)=0, so a|b covers every zero case.
              hcf_q   <= in1 | in2;
              lcm_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              state_q <= S_GCD;
            end
          end
        end
        S_GCD: begin
          if (x_q == y_q) begin
            g_q     <= x_q;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end else if (x_q > y_q) begin
            x_q <= x_q - y_q;
          end else begin
            y_q <= y_q - x_q;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[N-2:0], rem_ge_d};
          dvd_q <= {dvd_q[N-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q   <= acc_d;
          quo_q   <= {1'b0, quo_q[N-1:1]};
          mcand_q <= {mcand_q[2*N-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Results land on the same edge as the last partial product.
            hcf_q   <= g_q;
            lcm_q   <= acc_d;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hcf  = hcf_q;
  assign lcm  = lcm_q;

endmodule

// File: tb/tb_lcm_calculator.sv
// Testbench for lcm_calculator (N=8): directed cases, protocol scenarios and
// randomized operands checked against an arithmetic reference model.
module tb_lcm_calculator;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic           busy;
  logic           done;
  logic [N-1:0]   hcf;
  logic [2*N-1:0] lcm;

  int n_vec;
  int n_err;

  lcm_calculator #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .hcf   (hcf),
    .lcm   (lcm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: Euclid for the HCF, plain arithmetic for the LCM, and the
  // subtraction-step count only to predict the done cycle.
  task automatic model(input int a, input int b, output int g, output int l,
                       output int lat);
    int p, q, r, steps;
    if (a == 0 || b == 0) begin
      g = a | b;
      l = 0;
      lat = 1;
    end else begin
      p = a; q = b;
      while (q != 0) begin
        r = p % q; p = q; q = r;
      end
      g = p;
      l = (a / g) * b;
      p = a; q = b; steps = 0;
      while (p != q) begin
        if (p > q) p = p - q; else q = q - p;
        steps++;
      end
      lat = steps + 1 + 2 * N + 1;
    end
  endtask

  // Drives one request from an idle cycle (called #1 after a rising edge) and
  // reports what was observed; cycle 1 is the cycle after the accept edge.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output int cyc, output logic [N-1:0] h,
                       output logic [2*N-1:0] l, output logic busy_at_done,
                       output logic hold_ok, output logic busy_after,
                       output logic done_after);
    logic [N-1:0]   ph;
    logic [2*N-1:0] pl;
    ph = hcf; pl = lcm;
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && cyc < 400) begin
      if (hcf !== ph || lcm !== pl) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    h = hcf; l = lcm; busy_at_done = busy;
    @(posedge clk); #1;
    busy_after = busy; done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctrl busy/done got %b%b want 00", busy, done);
    end
    n_vec++;
    if (hcf !== '0 || lcm !== '0) begin
      n_err++; $display("FAIL reset_data hcf=%0d lcm=%0d want 0/0", hcf, lcm);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int a_t[6] = '{12, 7, 255, 0, 0, 9};
    int b_t[6] = '{18, 7, 254, 9, 0, 0};
    int cyc, g, l, lat;
    logic [N-1:0] h; logic [2*N-1:0] lo;
    logic bd, hok, ba, da;
    for (int i = 0; i < 6; i++) begin
      model(a_t[i], b_t[i], g, l, lat);
      do_op(N'(a_t[i]), N'(b_t[i]), cyc, h, lo, bd, hok, ba, da);
      n_vec++;
      if (cyc != lat) begin
        n_err++; $display("FAIL dir_latency a=%0d b=%0d done cycle %0d want %0d", a_t[i], b_t[i], cyc, lat);
      end
      n_vec++;
      if (h !== N'(g)) begin
        n_err++; $display("FAIL dir_hcf a=%0d b=%0d got %0d want %0d", a_t[i], b_t[i], h, g);
      end
      n_vec++;
      if (lo !== (2*N)'(l)) begin
        n_err++; $display("FAIL dir_lcm a=%0d b=%0d got %0d want %0d", a_t[i], b_t[i], lo, l);
      end
      n_vec++;
      if (bd !== 1'b1 || ba !== 1'b0 || da !== 1'b0) begin
        n_err++; $display("FAIL dir_handshake a=%0d b=%0d busy@done=%b busy/done after=%b%b want 1 00", a_t[i], b_t[i], bd, ba, da);
      end
      n_vec++;
      if (hok !== 1'b1) begin
        n_err++; $display("FAIL dir_hold a=%0d b=%0d results changed mid-computation got %b want 1", a_t[i], b_t[i], hok);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    logic [N-1:0] h; logic [2*N-1:0] lo;
    logic bd, hok, ba, da;
    in1 = 8'd12; in2 = 8'd18; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == 4) begin
        start = 1'b1; in1 = 8'd5; in2 = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_vec++;
    if (cyc != 20) begin
      n_err++; $display("FAIL ign_latency done cycle %0d want 20", cyc);
    end
    n_vec++;
    if (hcf !== 8'd6 || lcm !== 16'd36) begin
      n_err++; $display("FAIL ign_result hcf=%0d lcm=%0d want 6/36", hcf, lcm);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL ign_idle busy=%b want 0", busy);
    end
    do_op(8'd5, 8'd3, cyc, h, lo, bd, hok, ba, da);
    n_vec++;
    if (h !== 8'd1 || lo !== 16'd15) begin
      n_err++; $display("FAIL ign_second hcf=%0d lcm=%0d want 1/15", h, lo);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen_done, seen_busy;
    in1 = 8'd12; in2 = 8'd18; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy busy=%b want 1 before reset", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || hcf !== '0 || lcm !== '0) begin
      n_err++; $display("FAIL mid_reset busy=%b done=%b hcf=%0d lcm=%0d want 0 0 0 0", busy, done, hcf, lcm);
    end
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    n_vec++;
    if (seen_done !== 1'b0 || seen_busy !== 1'b0) begin
      n_err++; $display("FAIL mid_aborted done seen=%b busy seen=%b want 0 0", seen_done, seen_busy);
    end
  endtask

  task automatic test_rst_start_same();
    int cyc;
    logic [N-1:0] h; logic [2*N-1:0] lo;
    logic bd, hok, ba, da;
    do_op(8'd4, 8'd6, cyc, h, lo, bd, hok, ba, da);
    in1 = 8'd4; in2 = 8'd6; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || hcf !== '0 || lcm !== '0) begin
      n_err++; $display("FAIL rst_start busy=%b hcf=%0d lcm=%0d want 0 0 0", busy, hcf, lcm);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rst_start_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_random_back_to_back();
    int a, b, g, l, lat, cyc;
    logic [N-1:0] h; logic [2*N-1:0] lo;
    logic bd, hok, ba, da;
    for (int i = 0; i < 40; i++) begin
      a = (i % 7 == 3) ? 0 : int'($urandom_range(0, 255));
      b = (i % 11 == 5) ? 0 : int'($urandom_range(0, 255));
      model(a, b, g, l, lat);
      do_op(N'(a), N'(b), cyc, h, lo, bd, hok, ba, da);
      n_vec++;
      if (cyc != lat || h !== N'(g) || lo !== (2*N)'(l)) begin
        n_err++;
        $display("FAIL rnd_result a=%0d b=%0d cyc/hcf/lcm got %0d/%0d/%0d want %0d/%0d/%0d", a, b, cyc, h, lo, lat, g, l);
      end
      n_vec++;
      if (bd !== 1'b1 || ba !== 1'b0 || da !== 1'b0 || hok !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_protocol a=%0d b=%0d busy@done=%b after=%b%b hold=%b want 1 00 1", a, b, bd, ba, da, hok);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_rst_start_same();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
